mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_prio.sv | 37 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and the address legality helper for the data RAM arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   // 33-bit sum so addresses near the top of the 32-bit space cannot wrap.
   function automatic logic addr_ok(
      input logic [31:0] a,
      input int          mem_bytes,
      input logic        align
   );
      logic [32:0] w_end;
      w_end   = {1'b0, a} + 33'd3;
      addr_ok = (w_end <= 33'(mem_bytes - 1)) &&
                !(align && (a[1:0] != 2'b00));
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and data ports with a fetch starvation guard.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic d_req,
   input  logic i_arb_en,
   output logic o_owner
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

   logic [SW-1:0] r_streak;
   logic          w_force_i;

   assign w_force_i = i_req && (r_streak == LIM);
   assign o_owner   = (d_req && !w_force_i) ? OWN_D : OWN_I;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_streak <= '0;
      end else if (i_arb_en && (i_req || d_req)) begin
         if (o_owner == OWN_D && i_req) begin
            if (r_streak != LIM)
               r_streak <= r_streak + 1'b1;
         end else begin
            r_streak <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and strobe sequencer for the single-port data RAM.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_BYTES    = 1024,
   parameter int STARVE_LIMIT = 4,
   parameter int ALIGN_CHECK  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        mem_read,
   output logic        mem_write
);

   state_t      r_state;
   state_t      w_next;
   logic        w_owner;
   logic        w_arb_en;
   logic        w_win;
   logic        w_ok;
   logic        w_we;
   logic        w_i_ack;
   logic        w_d_ack;
   logic [31:0] w_addr;

   logic        r_owner;
   logic        r_err;
   logic        r_we;
   logic [31:0] r_rdata;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_mem_read;
   logic        r_mem_write;

   assign w_arb_en = (r_state == ST_IDLE);
   assign w_win    = w_arb_en && (i_req || d_req);
   assign w_addr   = (w_owner == OWN_D) ? d_addr : i_addr;
   assign w_we     = (w_owner == OWN_D) && d_we;
   assign w_ok     = addr_ok(w_addr, MEM_BYTES, ALIGN_CHECK != 0);

   mem_arb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (i_req),
      .d_req    (d_req),
      .i_arb_en (w_arb_en),
      .o_owner  (w_owner)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_i_ack = 1'b0;
      w_d_ack = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_win)
               w_next = w_ok ? ST_ACCESS : ST_RESP;
         end
         ST_ACCESS: w_next = ST_RESP;
         ST_RESP: begin
            w_next  = ST_IDLE;
            w_i_ack = (r_owner == OWN_I);
            w_d_ack = (r_owner == OWN_D);
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Strobes are registered so the RAM sees a full, glitch-free cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner     <= OWN_I;
         r_err       <= 1'b0;
         r_we        <= 1'b0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
      end else begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         if (w_win) begin
            r_owner     <= w_owner;
            r_we        <= w_we;
            r_err       <= !w_ok;
            r_rdata     <= '0;
            r_mem_read  <= w_ok && !w_we;
            r_mem_write <= w_ok && w_we;
            if (w_ok) begin
               r_mem_addr <= w_addr;
               if (w_owner == OWN_D)
                  r_mem_wdata <= d_wdata;
            end
         end
         if (r_state == ST_ACCESS && !r_we)
            r_rdata <= mem_rdata;
      end
   end

   assign i_ack     = w_i_ack;
   assign d_ack     = w_d_ack;
   assign i_err     = w_i_ack && r_err;
   assign d_err     = w_d_ack && r_err;
   assign i_rdata   = r_rdata;
   assign d_rdata   = r_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a big-endian 1 KB RAM model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_read;
   logic        mem_write;

   logic [7:0]  ram [0:1023];
   logic [9:0]  ra;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .MEM_BYTES    (1024),
      .STARVE_LIMIT (4),
      .ALIGN_CHECK  (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .i_err     (i_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write)
   );

   assign ra = mem_addr[9:0];
   assign mem_rdata = {ram[ra], ram[ra + 10'd1], ram[ra + 10'd2], ram[ra + 10'd3]};

   always @(posedge clk) begin
      if (mem_write) begin
         ram[ra]         <= mem_wdata[31:24];
         ram[ra + 10'd1] <= mem_wdata[23:16];
         ram[ra + 10'd2] <= mem_wdata[15:8];
         ram[ra + 10'd3] <= mem_wdata[7:0];
      end
   end

   typedef struct {
      logic        port_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   int cyc = 0;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      chk("ack_excl", {31'd0, i_ack && d_ack}, 32'd0);
      chk("strobe_excl", {31'd0, mem_read && mem_write}, 32'd0);
   endtask

   task automatic txn(
      input  logic        pd,
      input  logic        we,
      input  logic [31:0] a,
      input  logic [31:0] wd,
      output logic        ok,
      output logic        er,
      output logic [31:0] rd,
      output int          lat,
      output int          st,
      output logic [31:0] sa,
      output logic        other
   );
      ok = 0; er = 0; rd = '0; lat = 0; st = 0; sa = '0; other = 0;
      if (pd) begin
         d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
      end else begin
         i_req = 1; i_addr = a;
      end
      for (int c = 1; c <= 10 && !ok; c++) begin
         step();
         if (mem_read || mem_write) begin
            st++;
            sa = mem_addr;
         end
         if (pd ? i_ack : d_ack) other = 1;
         if (pd ? d_ack : i_ack) begin
            ok  = 1;
            lat = c;
            er  = pd ? d_err : i_err;
            rd  = pd ? d_rdata : i_rdata;
         end
      end
      i_req = 0; d_req = 0; d_we = 0;
      step();
   endtask

   initial begin
      logic        ok, er, oth;
      logic [31:0] rd, sa;
      int          lat, st, t1;
      logic        ord [6];
      int          nack;
      logic        quiet;

      vecs[0] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_03FC, 32'h0123_4567, 1'b0, 32'h0};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0123_4567};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
      vecs[5] = '{1'b0, 1'b0, 32'h0000_03FD, 32'h0,         1'b1, 32'h0};
      vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
      vecs[7] = '{1'b1, 1'b1, 32'h0000_0400, 32'h5555_AAAA, 1'b1, 32'h0};
      vecs[8] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vecs[9] = '{1'b1, 1'b1, 32'h0000_03FE, 32'h7777_7777, 1'b1, 32'h0};

      rst_n = 0; i_req = 0; i_addr = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
      chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", d_rdata, 32'd0);
      rst_n = 1;
      step();

      for (int v = 0; v < 10; v++) begin
         txn(vecs[v].port_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
             ok, er, rd, lat, st, sa, oth);
         chk($sformatf("v%0d_ack", v), {31'd0, ok}, 32'd1);
         chk($sformatf("v%0d_other", v), {31'd0, oth}, 32'd0);
         chk($sformatf("v%0d_err", v), {31'd0, er}, {31'd0, vecs[v].exp_err});
         chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
         chk($sformatf("v%0d_lat", v), lat, vecs[v].exp_err ? 32'd1 : 32'd2);
         chk($sformatf("v%0d_strobes", v), st, vecs[v].exp_err ? 32'd0 : 32'd1);
         if (!vecs[v].exp_err)
            chk($sformatf("v%0d_saddr", v), sa, vecs[v].addr);
      end

      chk("ram_10", {24'd0, ram[16]}, 32'hDE);
      chk("ram_11", {24'd0, ram[17]}, 32'hAD);
      chk("ram_12", {24'd0, ram[18]}, 32'hBE);
      chk("ram_13", {24'd0, ram[19]}, 32'hEF);

      // Both ports hammering: data wins four times, then fetch is forced in.
      i_req = 1; i_addr = 32'h10;
      d_req = 1; d_we = 0; d_addr = 32'h10;
      nack = 0;
      for (int c = 0; c < 40 && nack < 6; c++) begin
         step();
         if (d_ack || i_ack) begin
            ord[nack] = d_ack;
            nack++;
         end
      end
      i_req = 0; d_req = 0;
      step();
      chk("conflict_acks", nack, 32'd6);
      if (nack == 6) begin
         chk("conflict_0", {31'd0, ord[0]}, 32'd1);
         chk("conflict_1", {31'd0, ord[1]}, 32'd1);
         chk("conflict_2", {31'd0, ord[2]}, 32'd1);
         chk("conflict_3", {31'd0, ord[3]}, 32'd1);
         chk("conflict_4", {31'd0, ord[4]}, 32'd0);
         chk("conflict_5", {31'd0, ord[5]}, 32'd1);
      end

      // Back-to-back fetches with the address advanced at the ack edge.
      i_req = 1; i_addr = 32'h10;
      t1 = -1; nack = 0; rd = '0;
      for (int c = 0; c < 20 && nack < 2; c++) begin
         step();
         if (i_ack) begin
            nack++;
            if (nack == 1) begin
               t1 = cyc;
               chk("b2b_rd0", i_rdata, 32'hDEAD_BEEF);
               i_addr = 32'h3FC;
            end else begin
               chk("b2b_gap", cyc - t1, 32'd3);
               chk("b2b_rd1", i_rdata, 32'h0123_4567);
            end
         end
      end
      i_req = 0;
      step();
      chk("b2b_acks", nack, 32'd2);

      quiet = 1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (mem_read || mem_write || i_ack || d_ack) quiet = 0;
      end
      chk("idle_quiet", {31'd0, quiet}, 32'd1);
      chk("idle_addr_hold", mem_addr, 32'h3FC);

      // Reset lands in the middle of a write strobe.
      d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h1122_3344;
      step();
      chk("rst_mid_strobe", {31'd0, mem_write}, 32'd1);
      #2 rst_n = 0;
      #1;
      chk("rst_mid_drop", {31'd0, mem_write}, 32'd0);
      chk("rst_mid_addr", mem_addr, 32'd0);
      d_req = 0; d_we = 0;
      oth = 0;
      for (int c = 0; c < 2; c++) begin
         step();
         if (d_ack) oth = 1;
      end
      rst_n = 1;
      for (int c = 0; c < 2; c++) begin
         step();
         if (d_ack) oth = 1;
      end
      chk("rst_no_ack", {31'd0, oth}, 32'd0);
      chk("post_rst_outs",
          {26'd0, i_ack, d_ack, i_err, d_err, mem_read, mem_write}, 32'd0);
      chk("post_rst_mem_addr", mem_addr, 32'd0);
      chk("post_rst_mem_wdata", mem_wdata, 32'd0);
      chk("post_rst_rdata", i_rdata, 32'd0);

      txn(1'b1, 1'b0, 32'h10, 32'h0, ok, er, rd, lat, st, sa, oth);
      chk("post_rst_ack", {31'd0, ok}, 32'd1);
      chk("post_rst_lat", lat, 32'd2);
      chk("post_rst_rd", rd, 32'hDEAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
